axi_ram_resp: RTL and testbench

AXI4 memory responder: terminates one AXI4 master port of the crossbar and services write and read bursts against internal byte-enabled RAM. Independent write and read state machines run concurrently; each accepts one burst at a time. Full-width beats only (size not supported); FIXED, INCR and WRAP bursts supported.

---
 rtl/axi_ram_resp_pkg.sv | 36 +++
 rtl/axi_ram_burst_addr.sv | 37 +++
 rtl/axi_ram_resp.sv | 368 ++++++++++++++++++++++++++++++++++++
 tb/tb_axi_ram_resp.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ram_resp_pkg.sv
// axi_ram_resp_pkg
//   Shared definitions for the AXI4 RAM responder: AXI burst-type encodings,
//   the response code, the write/read state enums and the WRAP mask helper.
package axi_ram_resp_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic [0:0] {
        R_IDLE,
        R_DATA
    } r_state_t;

    // Word-index bits that wrap for a WRAP burst of (len+1) beats.
    // Zero means the length is not a legal wrap length, so the burst
    // behaves as INCR.
    function automatic logic [3:0] wrap_mask(input logic [7:0] len);
        case (len)
            8'd1:    return 4'h1;
            8'd3:    return 4'h3;
            8'd7:    return 4'h7;
            8'd15:   return 4'hF;
            default: return 4'h0;
        endcase
    endfunction

endpackage

// File: rtl/axi_ram_burst_addr.sv
// axi_ram_burst_addr
//   Combinational next-word-index calculator for one AXI burst beat.
//   Ports:
//     idx      in   IDX_W  word index of the current beat
//     len      in   8      burst length minus one
//     burst    in   2      FIXED / INCR / WRAP (reserved value acts as INCR)
//     next_idx out  IDX_W  word index of the following beat
//   The index wraps modulo 2^IDX_W, i.e. modulo the memory size.
module axi_ram_burst_addr
    import axi_ram_resp_pkg::*;
#(
    parameter int IDX_W = 14
) (
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       len,
    input  logic [1:0]       burst,
    output logic [IDX_W-1:0] next_idx
);

    localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

    logic [IDX_W-1:0] inc;
    logic [IDX_W-1:0] mask;

    always_comb begin
        inc      = idx + ONE;
        mask     = IDX_W'(wrap_mask(len));
        next_idx = inc;
        if (burst == BURST_FIXED) begin
            next_idx = idx;
        end else if ((burst == BURST_WRAP) && (mask != '0)) begin
            // Only the low wrap bits count; the upper bits stay put.
            next_idx = (idx & ~mask) | (inc & mask);
        end
    end

endmodule

// File: rtl/axi_ram_resp.sv
// axi_ram_resp
//   AXI4 slave that terminates one crossbar master port and services
//   write and read bursts against an internal byte-enabled RAM. The write
//   and read engines are independent and each handles one burst at a time.
//   Full-width beats only; FIXED, INCR and WRAP bursts.
//   Ports:
//     clk, rst          clock and synchronous active-high reset
//     s_axi_aw*         write address channel (id, addr, len, burst)
//     s_axi_w*          write data channel (wlast is not used for counting)
//     s_axi_b*          write response channel (bresp always OKAY)
//     s_axi_ar*         read address channel
//     s_axi_r*          read data channel (rresp always OKAY)
//   Build option:
//     AXI_RAM_RESP_PIPELINE_EN  adds a two-entry skid register on the R
//                               path; first rvalid moves from one to two
//                               cycles after the AR handshake.
module axi_ram_resp
    import axi_ram_resp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int OFF_W = $clog2(STRB_WIDTH);
    localparam int IDX_W = ADDR_WIDTH - OFF_W;
    localparam int DEPTH = 1 << IDX_W;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Low address bits are ignored (beats are aligned down) and wlast
    // does not drive the beat count.
    logic unused_inputs;
    assign unused_inputs = ^{s_axi_wlast, s_axi_awaddr[OFF_W-1:0], s_axi_araddr[OFF_W-1:0]};

    assign s_axi_bresp = RESP_OKAY;
    assign s_axi_rresp = RESP_OKAY;

    // ---------------------------------------------------------------- write
    w_state_t            w_state_q, w_state_d;
    logic                awready_q, awready_d;
    logic                wready_q,  wready_d;
    logic                bvalid_q,  bvalid_d;
    logic [ID_WIDTH-1:0] bid_q,     bid_d;
    logic [IDX_W-1:0]    w_idx_q,   w_idx_d;
    logic [7:0]          w_len_q,   w_len_d;
    logic [1:0]          w_burst_q, w_burst_d;
    logic [7:0]          w_cnt_q,   w_cnt_d;
    logic [IDX_W-1:0]    w_next;
    logic                aw_hs, w_hs;

    axi_ram_burst_addr #(.IDX_W(IDX_W)) u_w_addr (
        .idx      (w_idx_q),
        .len      (w_len_q),
        .burst    (w_burst_q),
        .next_idx (w_next)
    );

    assign aw_hs = awready_q & s_axi_awvalid;
    assign w_hs  = wready_q & s_axi_wvalid;

    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_burst_d = w_burst_q;
        w_cnt_d   = w_cnt_q;
        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (aw_hs) begin
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    bid_d     = s_axi_awid;
                    w_idx_d   = s_axi_awaddr[ADDR_WIDTH-1:OFF_W];
                    w_len_d   = s_axi_awlen;
                    w_burst_d = s_axi_awburst;
                    w_cnt_d   = 8'd0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    if (w_cnt_q == w_len_q) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        w_state_d = W_RESP;
                    end else begin
                        w_cnt_d = w_cnt_q + 8'd1;
                        w_idx_d = w_next;
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: begin
                awready_d = 1'b0;
                wready_d  = 1'b0;
                bvalid_d  = 1'b0;
                w_state_d = W_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        w_idx_q   <= w_idx_d;
        w_len_q   <= w_len_d;
        w_burst_q <= w_burst_d;
        w_cnt_q   <= w_cnt_d;
        if (rst) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
        end
    end

    // A beat arriving in the reset cycle belongs to an abandoned burst.
    always_ff @(posedge clk) begin
        if (w_hs && !rst) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[w_idx_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bid     = bid_q;

    // ----------------------------------------------------------------- read
    r_state_t              r_state_q, r_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q,  rvalid_d;
    logic                  rlast_q,   rlast_d;
    logic [ID_WIDTH-1:0]   rid_q,     rid_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [IDX_W-1:0]      r_idx_q,   r_idx_d;
    logic [7:0]            r_len_q,   r_len_d;
    logic [1:0]            r_burst_q, r_burst_d;
    logic [7:0]            r_cnt_q,   r_cnt_d;
    logic [IDX_W-1:0]      r_next;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_en;
    logic                  ar_hs, c_hs, c_ready;

    axi_ram_burst_addr #(.IDX_W(IDX_W)) u_r_addr (
        .idx      (r_idx_q),
        .len      (r_len_q),
        .burst    (r_burst_q),
        .next_idx (r_next)
    );

    assign ar_hs = arready_q & s_axi_arvalid;
    assign c_hs  = rvalid_q & c_ready;

    // The beat register always holds the beat being offered; the next word
    // is fetched on the edge that retires the current one. A write landing
    // on the same edge is not seen, so the read returns the old data.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_burst_d = r_burst_q;
        r_cnt_d   = r_cnt_q;
        rd_en     = 1'b0;
        rd_idx    = r_next;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rlast_d   = (s_axi_arlen == 8'd0);
                    rid_d     = s_axi_arid;
                    r_idx_d   = s_axi_araddr[ADDR_WIDTH-1:OFF_W];
                    r_len_d   = s_axi_arlen;
                    r_burst_d = s_axi_arburst;
                    r_cnt_d   = 8'd0;
                    rd_en     = 1'b1;
                    rd_idx    = s_axi_araddr[ADDR_WIDTH-1:OFF_W];
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (c_hs) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d = r_cnt_q + 8'd1;
                        r_idx_d = r_next;
                        rlast_d = ((r_cnt_q + 8'd1) == r_len_q);
                        rd_en   = 1'b1;
                    end
                end
            end
            default: begin
                arready_d = 1'b0;
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
                r_state_d = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        r_idx_q   <= r_idx_d;
        r_len_q   <= r_len_d;
        r_burst_q <= r_burst_d;
        r_cnt_q   <= r_cnt_d;
        if (rst) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_en) begin
            rdata_q <= mem[rd_idx];
        end
    end

    assign s_axi_arready = arready_q;

`ifdef AXI_RAM_RESP_PIPELINE_EN
    // Two-entry skid: ready back to the beat register depends only on the
    // registered occupancy, so rready never reaches it combinationally,
    // and one push plus one pop per cycle keeps full throughput.
    localparam logic [1:0] SK_FULL = 2'd2;

    logic [DATA_WIDTH-1:0] sk_data_q [2];
    logic [DATA_WIDTH-1:0] sk_data_d [2];
    logic [ID_WIDTH-1:0]   sk_id_q [2];
    logic [ID_WIDTH-1:0]   sk_id_d [2];
    logic [1:0]            sk_last_q, sk_last_d;
    logic                  sk_wp_q, sk_wp_d;
    logic                  sk_rp_q, sk_rp_d;
    logic [1:0]            sk_cnt_q, sk_cnt_d;
    logic                  sk_push, sk_pop;

    assign c_ready = (sk_cnt_q != SK_FULL);

    always_comb begin
        sk_push   = rvalid_q && (sk_cnt_q != SK_FULL);
        sk_pop    = (sk_cnt_q != 2'd0) && s_axi_rready;
        sk_data_d = sk_data_q;
        sk_id_d   = sk_id_q;
        sk_last_d = sk_last_q;
        sk_wp_d   = sk_wp_q;
        sk_rp_d   = sk_rp_q;
        sk_cnt_d  = sk_cnt_q;
        if (sk_push) begin
            sk_data_d[sk_wp_q] = rdata_q;
            sk_id_d[sk_wp_q]   = rid_q;
            sk_last_d[sk_wp_q] = rlast_q;
            sk_wp_d            = ~sk_wp_q;
        end
        if (sk_pop) begin
            sk_rp_d = ~sk_rp_q;
        end
        case ({sk_push, sk_pop})
            2'b10:   sk_cnt_d = sk_cnt_q + 2'd1;
            2'b01:   sk_cnt_d = sk_cnt_q - 2'd1;
            default: sk_cnt_d = sk_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                sk_data_q[i] <= '0;
                sk_id_q[i]   <= '0;
            end
            sk_last_q <= '0;
            sk_wp_q   <= 1'b0;
            sk_rp_q   <= 1'b0;
            sk_cnt_q  <= 2'd0;
        end else begin
            sk_data_q <= sk_data_d;
            sk_id_q   <= sk_id_d;
            sk_last_q <= sk_last_d;
            sk_wp_q   <= sk_wp_d;
            sk_rp_q   <= sk_rp_d;
            sk_cnt_q  <= sk_cnt_d;
        end
    end

    assign s_axi_rvalid = (sk_cnt_q != 2'd0);
    assign s_axi_rdata  = sk_data_q[sk_rp_q];
    assign s_axi_rid    = sk_id_q[sk_rp_q];
    assign s_axi_rlast  = sk_last_q[sk_rp_q];
`else
    assign c_ready      = s_axi_rready;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rid    = rid_q;
    assign s_axi_rlast  = rlast_q;
`endif

endmodule

// File: tb/tb_axi_ram_resp.sv
// tb_axi_ram_resp
//   Directed bench for axi_ram_resp. Stimulus tasks push expected B and R
//   responses into queues; an independent monitor pops and compares each
//   response as the DUT hands it over.
module tb_axi_ram_resp;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int SW = 4;
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [IW-1:0] s_axi_awid;
    logic [AW-1:0] s_axi_awaddr;
    logic [7:0]    s_axi_awlen;
    logic [1:0]    s_axi_awburst;
    logic          s_axi_awvalid;
    logic          s_axi_awready;
    logic [DW-1:0] s_axi_wdata;
    logic [SW-1:0] s_axi_wstrb;
    logic          s_axi_wlast;
    logic          s_axi_wvalid;
    logic          s_axi_wready;
    logic [IW-1:0] s_axi_bid;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready;
    logic [IW-1:0] s_axi_arid;
    logic [AW-1:0] s_axi_araddr;
    logic [7:0]    s_axi_arlen;
    logic [1:0]    s_axi_arburst;
    logic          s_axi_arvalid;
    logic          s_axi_arready;
    logic [IW-1:0] s_axi_rid;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rlast;
    logic          s_axi_rvalid;
    logic          s_axi_rready;

    always #5 clk = ~clk;

    axi_ram_resp dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_awid    (s_axi_awid),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awburst (s_axi_awburst),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bid     (s_axi_bid),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_arid    (s_axi_arid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready)
    );

    typedef struct {
        logic [31:0] data;
        logic [7:0]  id;
        logic        last;
    } r_exp_t;

    r_exp_t     rq[$];
    logic [7:0] bq[$];
    int         checks = 0;
    int         errors = 0;
    bit         toggle_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no handshake within cycle budget, expected one", name);
    endtask

    function automatic void push_r(input logic [31:0] d, input logic [7:0] id, input logic l);
        r_exp_t e;
        e.data = d;
        e.id   = id;
        e.last = l;
        rq.push_back(e);
    endfunction

    // rready: held high, or flipped every cycle while toggle_en is set.
    initial begin
        s_axi_rready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            s_axi_rready = toggle_en ? ~s_axi_rready : 1'b1;
        end
    end

    // Monitor: sampled on the falling edge, i.e. the values the next rising
    // edge will see.
    initial begin
        logic        stall;
        logic [31:0] hd;
        logic [7:0]  hid;
        logic        hl;
        stall = 1'b0;
        hd    = '0;
        hid   = '0;
        hl    = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("r_hold_valid", 32'(s_axi_rvalid), 32'd1);
                    chk("r_hold_data", s_axi_rdata, hd);
                    chk("r_hold_id", 32'(s_axi_rid), 32'(hid));
                    chk("r_hold_last", 32'(s_axi_rlast), 32'(hl));
                end
                if (s_axi_rvalid && s_axi_rready) begin
                    if (rq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL r_unexpected: got beat 0x%0h, expected no beat", s_axi_rdata);
                    end else begin
                        r_exp_t e;
                        e = rq.pop_front();
                        chk("rdata", s_axi_rdata, e.data);
                        chk("rid", 32'(s_axi_rid), 32'(e.id));
                        chk("rlast", 32'(s_axi_rlast), 32'(e.last));
                        chk("rresp", 32'(s_axi_rresp), 32'd0);
                    end
                end
                stall = s_axi_rvalid && !s_axi_rready;
                hd    = s_axi_rdata;
                hid   = s_axi_rid;
                hl    = s_axi_rlast;
                if (s_axi_bvalid && s_axi_bready) begin
                    if (bq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL b_unexpected: got bid 0x%0h, expected no response", s_axi_bid);
                    end else begin
                        logic [7:0] eb;
                        eb = bq.pop_front();
                        chk("bid", 32'(s_axi_bid), 32'(eb));
                        chk("bresp", 32'(s_axi_bresp), 32'd0);
                    end
                end
            end
        end
    end

    task automatic aw_req(input logic [7:0] id, input logic [15:0] addr,
                          input logic [7:0] len, input logic [1:0] burst);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        s_axi_awid    = id;
        s_axi_awaddr  = addr;
        s_axi_awlen   = len;
        s_axi_awburst = burst;
        s_axi_awvalid = 1'b1;
        @(negedge clk);
        while (!s_axi_awready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_axi_awready) timeout_fail("aw_timeout");
        @(posedge clk);
        #1;
        s_axi_awvalid = 1'b0;
    endtask

    task automatic ar_req(input logic [7:0] id, input logic [15:0] addr,
                          input logic [7:0] len, input logic [1:0] burst);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        s_axi_arid    = id;
        s_axi_araddr  = addr;
        s_axi_arlen   = len;
        s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        @(negedge clk);
        while (!s_axi_arready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_axi_arready) timeout_fail("ar_timeout");
        @(posedge clk);
        #1;
        s_axi_arvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n;
        n = 0;
        s_axi_wdata  = data;
        s_axi_wstrb  = strb;
        s_axi_wlast  = last;
        s_axi_wvalid = 1'b1;
        @(negedge clk);
        while (!s_axi_wready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_axi_wready) timeout_fail("w_timeout");
        @(posedge clk);
        #1;
        s_axi_wvalid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (rq.size() != 0 || bq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: %0d R and %0d B responses outstanding, expected 0",
                     name, rq.size(), bq.size());
            rq.delete();
            bq.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        s_axi_awid    = '0;
        s_axi_awaddr  = '0;
        s_axi_awlen   = '0;
        s_axi_awburst = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wlast   = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b1;
        s_axi_arid    = '0;
        s_axi_araddr  = '0;
        s_axi_arlen   = '0;
        s_axi_arburst = '0;
        s_axi_arvalid = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", 32'(s_axi_awready), 32'd0);
        chk("rst_arready", 32'(s_axi_arready), 32'd0);
        chk("rst_wready", 32'(s_axi_wready), 32'd0);
        chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        chk("rst_rlast", 32'(s_axi_rlast), 32'd0);
        chk("rst_bid", 32'(s_axi_bid), 32'd0);
        chk("rst_rid", 32'(s_axi_rid), 32'd0);
        chk("rst_rdata", s_axi_rdata, 32'd0);
        chk("rst_bresp", 32'(s_axi_bresp), 32'd0);
        chk("rst_rresp", 32'(s_axi_rresp), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_awready", 32'(s_axi_awready), 32'd1);
        chk("post_rst_arready", 32'(s_axi_arready), 32'd1);
        chk("post_rst_wready", 32'(s_axi_wready), 32'd0);

        // INCR write 0x10 len 3, then read it back
        bq.push_back(8'h05);
        aw_req(8'h05, 16'h0010, 8'd3, 2'd1);
        for (int i = 0; i < 4; i++) w_beat(32'hA0 + i, 4'hF, i == 3);
        wait_idle("incr_write");
        for (int i = 0; i < 4; i++) push_r(32'hA0 + i, 8'h05, i == 3);
        ar_req(8'h05, 16'h0010, 8'd3, 2'd1);
        wait_idle("incr_read");

        // Words 0xC..0xF, then WRAP read from 0x38 -> E, F, C, D
        bq.push_back(8'h01);
        aw_req(8'h01, 16'h0030, 8'd3, 2'd1);
        w_beat(32'hC0, 4'hF, 1'b0);
        w_beat(32'hD0, 4'hF, 1'b0);
        w_beat(32'hE0, 4'hF, 1'b0);
        w_beat(32'hF0, 4'hF, 1'b1);
        wait_idle("wrap_setup");
        push_r(32'hE0, 8'h02, 1'b0);
        push_r(32'hF0, 8'h02, 1'b0);
        push_r(32'hC0, 8'h02, 1'b0);
        push_r(32'hD0, 8'h02, 1'b1);
        ar_req(8'h02, 16'h0038, 8'd3, 2'd2);
        wait_idle("wrap_read");

        // FIXED write with partial strobe, FIXED read of two beats
        bq.push_back(8'h03);
        aw_req(8'h03, 16'h0020, 8'd1, 2'd0);
        w_beat(32'h11111111, 4'hF, 1'b0);
        w_beat(32'h22222222, 4'h3, 1'b1);
        wait_idle("fixed_write");
        push_r(32'h11112222, 8'h03, 1'b0);
        push_r(32'h11112222, 8'h03, 1'b1);
        ar_req(8'h03, 16'h0020, 8'd1, 2'd0);
        wait_idle("fixed_read");

        // Eight words at 0x40, read back with rready toggling
        bq.push_back(8'h04);
        aw_req(8'h04, 16'h0040, 8'd7, 2'd1);
        for (int i = 0; i < 8; i++) w_beat(32'h100 + i, 4'hF, i == 7);
        wait_idle("len8_write");
        toggle_en = 1'b1;
        for (int i = 0; i < 8; i++) push_r(32'h100 + i, 8'h06, i == 7);
        ar_req(8'h06, 16'h0040, 8'd7, 2'd1);
        wait_idle("stall_read");
        toggle_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Concurrent write and read from the same start word
        bq.push_back(8'h07);
        for (int i = 0; i < 4; i++) push_r(32'h100 + i, 8'h08, i == 3);
        fork
            begin
                aw_req(8'h07, 16'h0040, 8'd3, 2'd1);
                for (int i = 0; i < 4; i++) w_beat(32'h200 + i, 4'hF, i == 3);
            end
            begin
                ar_req(8'h08, 16'h0040, 8'd3, 2'd1);
            end
        join
        wait_idle("concurrent");
        for (int i = 0; i < 4; i++) push_r(32'h200 + i, 8'h09, i == 3);
        ar_req(8'h09, 16'h0040, 8'd3, 2'd1);
        wait_idle("after_concurrent");

        // WRAP with len 2 is not a wrap length: behaves as INCR (E, F, 0x10)
        push_r(32'hE0, 8'h0A, 1'b0);
        push_r(32'hF0, 8'h0A, 1'b0);
        push_r(32'h200, 8'h0A, 1'b1);
        ar_req(8'h0A, 16'h0038, 8'd2, 2'd2);
        wait_idle("wrap_len2");

        // INCR past the top word wraps to word 0; unaligned address aligns down
        bq.push_back(8'h0B);
        aw_req(8'h0B, 16'hFFFC, 8'd1, 2'd1);
        w_beat(32'h5555AAAA, 4'hF, 1'b0);
        w_beat(32'h12345678, 4'hF, 1'b1);
        wait_idle("top_write");
        push_r(32'h12345678, 8'h0C, 1'b1);
        ar_req(8'h0C, 16'h0000, 8'd0, 2'd1);
        wait_idle("word0_read");
        push_r(32'h5555AAAA, 8'h0D, 1'b1);
        ar_req(8'h0D, 16'hFFFE, 8'd0, 2'd1);
        wait_idle("unaligned_read");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
